// File: rtl/mem_access_unit_if.sv
// Bundle between the execute/writeback datapath, the data RAM and the
// switch/LED window as seen by mem_access_unit.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_WIDTH = 14
);
    logic [31:0]           ALUResult;
    logic [31:0]           ReadData2;
    logic [2:0]            funct3;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  mem_stall;
    logic [31:0]           MemData;
    logic                  access_fault;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [3:0]            ram_we;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic [15:0]           io_switch;
    logic [15:0]           io_led;

    modport master (
        output ALUResult, ReadData2, funct3, MemRead, MemWrite,
        output ram_rdata, io_switch,
        input  mem_stall, MemData, access_fault,
        input  ram_addr, ram_we, ram_wdata, io_led
    );

    modport slave (
        input  ALUResult, ReadData2, funct3, MemRead, MemWrite,
        input  ram_rdata, io_switch,
        output mem_stall, MemData, access_fault,
        output ram_addr, ram_we, ram_wdata, io_led
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I memory stage: RAM load/store with 1-cycle read latency,
// load formatting, access-fault detection and a switch/LED MMIO window.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FC00
) (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] load_q;
    logic [1:0]  lo_q;
    logic [2:0]  f3_q;
    logic [15:0] led_q;

    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] rs2;
    logic [5:0]  woff;
    logic        idle;
    logic        mmio_hit;
    logic        fault;
    logic        ld_start;
    logic        st_ram;
    logic        mmio_rd;
    logic        st_led;
    logic [31:0] mmio_raw;

    function automatic logic [31:0] fmt(
        input logic [31:0] d,
        input logic [1:0]  a,
        input logic [2:0]  f
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {a, 3'b000});
        h = a[1] ? d[31:16] : d[15:0];
        unique case (f)
            3'b000:  fmt = {{24{b[7]}}, b};
            3'b001:  fmt = {{16{h[15]}}, h};
            3'b100:  fmt = {24'h0, b};
            3'b101:  fmt = {16'h0, h};
            default: fmt = d;
        endcase
    endfunction

    assign addr     = bus.ALUResult;
    assign f3       = bus.funct3;
    assign rs2      = bus.ReadData2;
    assign woff     = addr[7:2];
    // Reset gates the request path so stall drops the instant rst rises.
    assign idle     = (state == IDLE) && !rst;
    assign mmio_hit = (addr[31:8] == MMIO_BASE[31:8]);

    always_comb begin
        fault = 1'b0;
        if (idle) begin
            if (bus.MemRead && bus.MemWrite) begin
                fault = 1'b1;
            end else if (bus.MemRead) begin
                unique case (f3)
                    3'b000, 3'b100: fault = 1'b0;
                    3'b001, 3'b101: fault = addr[0];
                    3'b010:         fault = |addr[1:0];
                    default:        fault = 1'b1;
                endcase
            end else if (bus.MemWrite) begin
                unique case (f3)
                    3'b000:  fault = 1'b0;
                    3'b001:  fault = addr[0];
                    3'b010:  fault = |addr[1:0];
                    default: fault = 1'b1;
                endcase
            end
        end
    end

    assign ld_start = idle && bus.MemRead && !fault && !mmio_hit;
    assign st_ram   = idle && bus.MemWrite && !fault && !mmio_hit;
    assign mmio_rd  = idle && bus.MemRead && !fault && mmio_hit;
    assign st_led   = idle && bus.MemWrite && !fault && mmio_hit
                      && (woff == 6'd1);

    always_comb begin
        mmio_raw = 32'h0;
        unique case (1'b1)
            woff == 6'd0: mmio_raw = {16'h0, bus.io_switch};
            woff == 6'd1: mmio_raw = {16'h0, led_q};
            default:      mmio_raw = 32'h0;
        endcase
    end

    always_comb begin
        bus.ram_we = 4'b0000;
        if (st_ram) begin
            unique case (f3)
                3'b000:  bus.ram_we = 4'b0001 << addr[1:0];
                3'b001:  bus.ram_we = addr[1] ? 4'b1100 : 4'b0011;
                default: bus.ram_we = 4'b1111;
            endcase
        end
    end

    always_comb begin
        unique case (f3)
            3'b000:  bus.ram_wdata = {4{rs2[7:0]}};
            3'b001:  bus.ram_wdata = {2{rs2[15:0]}};
            default: bus.ram_wdata = rs2;
        endcase
    end

    always_comb begin
        bus.MemData = 32'h0;
        unique case (1'b1)
            state == DONE: bus.MemData = load_q;
            mmio_rd:       bus.MemData = fmt(mmio_raw, addr[1:0], f3);
            default:       bus.MemData = 32'h0;
        endcase
    end

    assign bus.ram_addr     = addr[ADDR_WIDTH+1:2];
    assign bus.mem_stall    = ld_start || ((state == RD_WAIT) && !rst);
    assign bus.access_fault = fault;
    assign bus.io_led       = led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            load_q <= 32'h0;
            lo_q   <= 2'b00;
            f3_q   <= 3'b000;
            led_q  <= 16'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ld_start) begin
                        state <= RD_WAIT;
                        lo_q  <= addr[1:0];
                        f3_q  <= f3;
                    end
                end
                RD_WAIT: begin
                    load_q <= fmt(bus.ram_rdata, lo_q, f3_q);
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // Byte stores only reach the LED lanes that exist.
            if (st_led) begin
                if (f3 == 3'b000) begin
                    if (addr[1:0] == 2'b00) led_q[7:0] <= rs2[7:0];
                    if (addr[1:0] == 2'b01) led_q[15:8] <= rs2[7:0];
                end else begin
                    led_q <= rs2[15:0];
                end
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage directly downstream of the ALU in the RV32I datapath.
- Takes the ALU result as the effective address, rs2 read data as store data, and funct3 as access width/sign.
- Drives a synchronous block RAM with 1-cycle read latency, plus a small MMIO window for switches and LEDs.
- Formats load data and stalls the PC/register-file write for the duration of a RAM load.

Parameters:
- ADDR_WIDTH, 14, word-address bits presented to the RAM (64 KiB data space).
- MMIO_BASE, 32'hFFFF_FC00, base of the MMIO window; a hit is ALUResult[31:8] == MMIO_BASE[31:8].

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ALUResult  in  32  effective byte address
- ReadData2  in  32  store data (rs2)
- funct3  in  3  access type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (loads); 000 sb, 001 sh, 010 sw (stores)
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store
- mem_stall  out  1  hold PC and suppress register write-back while 1
- MemData  out  32  formatted load result; valid when MemRead=1 and mem_stall=0
- access_fault  out  1  misaligned or illegal access this cycle
- ram_addr  out  ADDR_WIDTH  word address = ALUResult[ADDR_WIDTH+1:2]
- ram_we  out  4  byte write enables
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  RAM read data, valid one cycle after ram_addr
- io_switch  in  16  switch inputs
- io_led  out  16  LED register

Behaviour:
- FSM states: IDLE, RD_WAIT, DONE. Reset → IDLE, io_led=0, load register=0. Reset mid-RD_WAIT/DONE returns to IDLE immediately; mem_stall deasserts asynchronously; no write occurs.
- Fault check (combinational, IDLE only):
  - MemRead and MemWrite both 1 → fault.
  - Load funct3 in {011,110,111} or store funct3 not in {000,001,010} → fault.
  - lw/sw with addr[1:0]≠0 → fault.
  - lh/lhu/sh with addr[0]≠0 → fault.
  - On fault: access_fault=1, ram_we=0, no LED update, MemData=0, mem_stall=0, state stays IDLE.
- RAM load: IDLE with MemRead, no fault, no MMIO hit → mem_stall=1, next state RD_WAIT.
  - RD_WAIT: mem_stall=1; capture formatted ram_rdata into the load register; next state DONE.
  - DONE: mem_stall=0; MemData = load register; next state IDLE unconditionally. The instruction retires on this edge.
  - Total: 3 cycles per RAM load.
- Load formatting: byte = rdata[8*addr[1:0] +: 8]; half = addr[1] ? rdata[31:16] : rdata[15:0]. lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- RAM store: IDLE with MemWrite, no fault, no MMIO hit. Single cycle, mem_stall=0.
  - sb: ram_we = 4'b0001 << addr[1:0], ram_wdata = {4{rs2[7:0]}}.
  - sh: ram_we = addr[1] ? 4'b1100 : 4'b0011, ram_wdata = {2{rs2[15:0]}}.
  - sw: ram_we = 4'b1111, ram_wdata = rs2.
- ram_we=0 whenever not in IDLE, on fault, on MMIO hit, or with MemWrite=0.
- ram_addr always reflects ALUResult; upper address bits above ADDR_WIDTH+1 are ignored (aliasing).
- MMIO (no stall, no RAM access):
  - Offset 0x00: switches, read-only; load returns io_switch zero-extended to 32 bits, then width-formatted as for RAM.
  - Offset 0x04: LEDs; a store updates io_led at the clock edge (sw/sh take rs2[15:0]; sb writes the addressed byte lane if it falls in [15:0], otherwise ignored); a load returns {16'b0, io_led}.
  - Other offsets: reads return 0, writes ignored, no fault.
- MemRead=MemWrite=0 → mem_stall=0, ram_we=0, MemData=0, access_fault=0.

Test Plan:
- sw rs2=32'hDEADBEEF @0x10, then lw @0x10 → ram_we=4'b1111; mem_stall high for exactly 2 cycles; MemData=32'hDEADBEEF in DONE.
- sb rs2=32'h000000A5 @0x13, then lb @0x13 and lbu @0x13 → ram_we=4'b1000, ram_wdata=32'hA5A5A5A5; lb → 32'hFFFFFFA5; lbu → 32'h000000A5.
- lh @0x12 on word 32'h8001_7FFF → 32'hFFFF8001; lhu @0x10 → 32'h00007FFF.
- lw @0x11 and sh @0x13 → access_fault=1, ram_we=0, mem_stall=0, FSM stays IDLE.
- sw 32'h1234 to MMIO_BASE+4, then lw MMIO_BASE+0 with io_switch=16'hF00F → io_led=16'h1234 next edge; MemData=32'h0000F00F with no stall.
- Assert rst during RD_WAIT → mem_stall=0 immediately, state IDLE, io_led=0; a subsequent lw completes normally in 3 cycles.
